change_dispenser: RTL and testbench

Downstream stage of the vending control FSM. When the FSM enters its charge (change-return) phase, this block latches the remaining credit `coin_val_sum` and pays it out one item at a time to the coin/note hopper. It uses greedy denomination selection and a valid/ready plus done handshake per item. It reports progress and completion, and flags a hopper timeout.

---
 rtl/change_dispenser.sv | 177 +++++++++++++++++
 tb/tb_change_dispenser.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//
// Purpose: pays out the remaining credit to the coin/note hopper after the
// vending controller enters its change-return phase. The credit is latched
// on a rising edge of charge_req and dispensed one item at a time, always
// choosing the largest enabled denomination that still fits.
//
// Build option: define CHG_BIG_NOTES_EN to enable the 100r/50r/20r notes
// (codes 0-2). Without it, selection starts at the 10r coin (code 3).
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   charge_req    in   level from control FSM; rising edge starts a payout
//   coin_val_sum  in   credit to return, half-yuan units (11 bits)
//   hopper_ready  in   hopper can accept a dispense command
//   hopper_done   in   one-cycle pulse: commanded item has left the hopper
//   disp_valid    out  dispense command valid
//   disp_denom    out  denomination code (0=100r ... 6=0.5r)
//   remaining     out  credit still to pay out, half-yuan units
//   busy          out  payout in progress
//   charge_done   out  one-cycle pulse: payout complete
//   err_timeout   out  sticky hopper-timeout flag
//
// Handshake: a dispense command transfers on a rising clk edge where
// disp_valid && hopper_ready. disp_valid never drops and disp_denom never
// changes before that transfer. After the transfer, the item completes on a
// later hopper_done pulse; done pulses at any other time are ignored.

module change_dispenser #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter logic [10:0] MAX_SUM        = 11'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        charge_req,
  input  logic [10:0] coin_val_sum,
  input  logic        hopper_ready,
  input  logic        hopper_done,
  output logic        disp_valid,
  output logic [2:0]  disp_denom,
  output logic [10:0] remaining,
  output logic        busy,
  output logic        charge_done,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

`ifdef CHG_BIG_NOTES_EN
  localparam int FIRST_CODE = 0;
`else
  localparam int FIRST_CODE = 3;
`endif

  state_e      state_q, state_d;
  logic        req_q;
  logic [10:0] rem_q, rem_d;
  logic [2:0]  denom_q, denom_d;
  logic        err_q, err_d;
  logic [23:0] cnt_q, cnt_d;
  logic        start;

  // Value of each denomination code in half-yuan units.
  function automatic logic [10:0] denom_value(input logic [2:0] code);
    logic [10:0] v;
    case (code)
      3'd0:    v = 11'd200;
      3'd1:    v = 11'd100;
      3'd2:    v = 11'd40;
      3'd3:    v = 11'd20;
      3'd4:    v = 11'd10;
      3'd5:    v = 11'd2;
      3'd6:    v = 11'd1;
      default: v = 11'd0;
    endcase
    return v;
  endfunction

  // Scan from the smallest coin upwards, so the last code that fits is the
  // largest one. Code 6 (value 1) always fits a non-zero amount.
  function automatic logic [2:0] pick_denom(input logic [10:0] amt);
    logic [2:0] code;
    code = 3'd6;
    for (int i = 6; i >= FIRST_CODE; i--) begin
      if (amt >= denom_value(3'(i))) code = 3'(i);
    end
    return code;
  endfunction

  assign start = charge_req & ~req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      rem_q   <= 11'd0;
      denom_q <= 3'd0;
      err_q   <= 1'b0;
      cnt_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      req_q   <= charge_req;
      rem_q   <= rem_d;
      denom_q <= denom_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    denom_d = denom_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = (coin_val_sum > MAX_SUM) ? MAX_SUM : coin_val_sum;
          err_d   = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 11'd0) begin
          state_d = S_FINISH;
        end else begin
          denom_d = pick_denom(rem_q);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // No timeout here: a hopper that is not ready may stall forever.
        if (hopper_ready) begin
          cnt_d   = 24'd0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (hopper_done) begin
          rem_d   = rem_q - denom_value(denom_q);
          state_d = S_SELECT;
        end else if (cnt_q + 24'd1 == TIMEOUT_CYCLES) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        err_d = 1'b1;
        if (!charge_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign disp_valid  = (state_q == S_ISSUE);
  assign disp_denom  = denom_q;
  assign remaining   = rem_q;
  assign busy        = (state_q == S_SELECT) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT_DONE) || (state_q == S_FINISH);
  assign charge_done = (state_q == S_FINISH);
  // FAULT is visible in the same cycle it is entered; the register keeps it.
  assign err_timeout = err_q || (state_q == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.

module tb_change_dispenser;

  logic        clk;
  logic        rst;
  logic        charge_req;
  logic [10:0] coin_val_sum;
  logic        hopper_ready;
  logic        hopper_done;
  logic        disp_valid;
  logic [2:0]  disp_denom;
  logic [10:0] remaining;
  logic        busy;
  logic        charge_done;
  logic        err_timeout;

  int vectors;
  int miscompares;

  logic [2:0]  exp_q[$];
  logic [10:0] rem_q[$];

  change_dispenser #(
    .TIMEOUT_CYCLES(24'd16),
    .MAX_SUM       (11'd2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .charge_req  (charge_req),
    .coin_val_sum(coin_val_sum),
    .hopper_ready(hopper_ready),
    .hopper_done (hopper_done),
    .disp_valid  (disp_valid),
    .disp_denom  (disp_denom),
    .remaining   (remaining),
    .busy        (busy),
    .charge_done (charge_done),
    .err_timeout (err_timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; charge_req = 1'b0; coin_val_sum = 11'd0;
    hopper_ready = 1'b0; hopper_done = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (disp_valid !== 1'b0 || busy !== 1'b0 || charge_done !== 1'b0 ||
        err_timeout !== 1'b0 || remaining !== 11'd0 || disp_denom !== 3'd0) begin
      miscompares++;
      $display("FAIL reset: valid=%0b busy=%0b done=%0b err=%0b rem=%0d denom=%0d, required all 0",
               disp_valid, busy, charge_done, err_timeout, remaining, disp_denom);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one payout with hopper_ready high and done two cycles after each
  // accept, checking against exp_q (codes) and rem_q (remaining after each).
  task automatic run_payout(input logic [10:0] amt);
    int guard;
    logic [2:0]  d;
    logic [10:0] r;
    hopper_ready = 1'b1; coin_val_sum = amt; charge_req = 1'b1;
    @(negedge clk);
    coin_val_sum = 11'd99;  // changes after the latch must not matter
    vectors++;
    if (busy !== 1'b1 || disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL start: busy=%0b valid=%0b, required busy=1 valid=0", busy, disp_valid);
    end
    while (exp_q.size() > 0) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (disp_valid !== 1'b1 && guard < 8);
      vectors++;
      if (guard != 1) begin
        miscompares++;
        $display("FAIL item_latency: %0d cycles, required 1", guard);
      end
      if (disp_valid !== 1'b1) break;
      d = exp_q.pop_front();
      vectors++;
      if (disp_denom !== d) begin
        miscompares++;
        $display("FAIL denom: got %0d, required %0d", disp_denom, d);
      end
      @(negedge clk);
      vectors++;
      if (disp_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL accept: valid=%0b busy=%0b, required valid=0 busy=1", disp_valid, busy);
      end
      @(negedge clk);
      hopper_done = 1'b1;
      @(negedge clk);
      hopper_done = 1'b0;
      r = rem_q.pop_front();
      vectors++;
      if (remaining !== r) begin
        miscompares++;
        $display("FAIL remaining: got %0d, required %0d", remaining, r);
      end
    end
    guard = 0;
    do begin @(negedge clk); guard++; end while (charge_done !== 1'b1 && guard < 4);
    vectors++;
    if (charge_done !== 1'b1 || guard != 1) begin
      miscompares++;
      $display("FAIL charge_done: got %0b after %0d cycles, required 1 after 1", charge_done, guard);
    end
    @(negedge clk);
    vectors++;
    if (charge_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_done: done=%0b busy=%0b, required 0 0", charge_done, busy);
    end
    charge_req = 1'b0;
    exp_q.delete(); rem_q.delete();
    @(negedge clk);
  endtask

  task automatic test_amount_37();
    exp_q = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6};
    rem_q = '{11'd17, 11'd7, 11'd5, 11'd3, 11'd1, 11'd0};
    run_payout(11'd37);
  endtask

  task automatic test_saturation();
    exp_q.delete(); rem_q.delete();
`ifdef CHG_BIG_NOTES_EN
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(3'd0);
      rem_q.push_back(11'(2000 - 200 * k));
    end
`else
    for (int k = 1; k <= 100; k++) begin
      exp_q.push_back(3'd3);
      rem_q.push_back(11'(2000 - 20 * k));
    end
`endif
    run_payout(11'd2047);
  endtask

  task automatic test_zero();
    hopper_ready = 1'b1; coin_val_sum = 11'd0; charge_req = 1'b1;
    @(negedge clk);  // N+1
    vectors++;
    if (busy !== 1'b1 || charge_done !== 1'b0 || disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_n1: busy=%0b done=%0b valid=%0b, required 1 0 0", busy, charge_done, disp_valid);
    end
    @(negedge clk);  // N+2
    vectors++;
    if (busy !== 1'b1 || charge_done !== 1'b1 || disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_n2: busy=%0b done=%0b valid=%0b, required 1 1 0", busy, charge_done, disp_valid);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || charge_done !== 1'b0 || disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_n3: busy=%0b done=%0b valid=%0b, required 0 0 0", busy, charge_done, disp_valid);
    end
    charge_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ready_stall();
    hopper_ready = 1'b0; coin_val_sum = 11'd20; charge_req = 1'b1;
    @(negedge clk); @(negedge clk);  // ISSUE
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (disp_valid !== 1'b1 || disp_denom !== 3'd3 || remaining !== 11'd20) begin
        miscompares++;
        $display("FAIL stall[%0d]: valid=%0b denom=%0d rem=%0d, required 1 3 20",
                 i, disp_valid, disp_denom, remaining);
      end
      if (i == 1) charge_req = 1'b0;
      if (i == 3) charge_req = 1'b1;  // edge while busy must be ignored
      hopper_done = (i == 2);         // done outside WAIT_DONE must be ignored
      if (i == 5) hopper_ready = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (disp_valid !== 1'b0 || remaining !== 11'd20) begin
      miscompares++;
      $display("FAIL stall_accept: valid=%0b rem=%0d, required 0 20", disp_valid, remaining);
    end
    @(negedge clk);
    hopper_done = 1'b1;
    @(negedge clk);
    hopper_done = 1'b0;
    vectors++;
    if (remaining !== 11'd0) begin
      miscompares++;
      $display("FAIL stall_rem: got %0d, required 0", remaining);
    end
    @(negedge clk);
    vectors++;
    if (charge_done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_done: got %0b, required 1", charge_done);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_no_restart: busy=%0b, required 0", busy);
    end
    charge_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cnt;
    hopper_ready = 1'b1; coin_val_sum = 11'd1; charge_req = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (disp_valid !== 1'b1 || disp_denom !== 3'd6) begin
      miscompares++;
      $display("FAIL to_issue: valid=%0b denom=%0d, required 1 6", disp_valid, disp_denom);
    end
    @(negedge clk);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    vectors++;
    if (cnt != 16) begin
      miscompares++;
      $display("FAIL to_cycles: %0d wait cycles, required 16", cnt);
    end
    vectors++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || remaining !== 11'd1 || disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL to_fault: err=%0b busy=%0b rem=%0d valid=%0b, required 1 0 1 0",
               err_timeout, busy, remaining, disp_valid);
    end
    hopper_done = 1'b1;
    @(negedge clk);
    hopper_done = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || remaining !== 11'd1) begin
      miscompares++;
      $display("FAIL to_frozen: err=%0b busy=%0b rem=%0d, required 1 0 1", err_timeout, busy, remaining);
    end
    charge_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_idle: err=%0b busy=%0b, required 1 0", err_timeout, busy);
    end
    coin_val_sum = 11'd0; charge_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL to_clear: err=%0b busy=%0b, required 0 1", err_timeout, busy);
    end
    @(negedge clk);
    @(negedge clk);
    charge_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    hopper_ready = 1'b1; coin_val_sum = 11'd37; charge_req = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (disp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_issue: valid=%0b, required 1", disp_valid);
    end
    @(negedge clk);  // WAIT_DONE
    rst = 1'b1; charge_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; hopper_done = 1'b1;
    vectors++;
    if (disp_valid !== 1'b0 || busy !== 1'b0 || charge_done !== 1'b0 ||
        err_timeout !== 1'b0 || remaining !== 11'd0 || disp_denom !== 3'd0) begin
      miscompares++;
      $display("FAIL rw_reset: valid=%0b busy=%0b done=%0b err=%0b rem=%0d denom=%0d, required all 0",
               disp_valid, busy, charge_done, err_timeout, remaining, disp_denom);
    end
    @(negedge clk);
    hopper_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (remaining !== 11'd0 || busy !== 1'b0 || disp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_after: rem=%0d busy=%0b valid=%0b, required 0 0 0", remaining, busy, disp_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_amount_37();
    test_zero();
    test_ready_stall();
    test_saturation();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
